// File: rtl/regfile_scoreboard.sv
// Register file with async read ports, bypassed sync write, hardwired-zero r0,
// a per-register busy scoreboard, and a sequential clear sweep after reset.
module regfile_scoreboard #(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 16,
    parameter int NUM_RD_PORTS = 3,
    localparam int SEL_W       = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            ready,
    input  logic [NUM_RD_PORTS*SEL_W-1:0]   rd_sel,
    output logic [NUM_RD_PORTS*DATA_W-1:0]  rd_data,
    output logic [NUM_RD_PORTS-1:0]         rd_busy,
    input  logic                            wr_en,
    input  logic [SEL_W-1:0]                wr_sel,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rsv_en,
    input  logic [SEL_W-1:0]                rsv_sel,
    output logic                            rsv_ack
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SEL_W-1:0]    clr_idx;
    logic [NUM_REGS-1:0] busy;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                run;
    logic                wr_live;
    logic                clr_last;

    // ready is the state itself: high exactly when the FSM is in RUN.
    assign run      = (state == RUN);
    assign ready    = run;
    assign wr_live  = run && wr_en;
    assign clr_last = (clr_idx == SEL_W'(NUM_REGS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_last) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else if (wr_en && wr_sel != '0) begin
                regs[wr_sel] <= wr_data;
            end
        end
    end

    // A reservation of a register being written back this cycle is accepted;
    // the set is applied after the clear so the reservation wins.
    assign rsv_ack = run && rsv_en && (rsv_sel != '0) &&
                     (!busy[rsv_sel] || (wr_en && wr_sel == rsv_sel));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (run) begin
            if (wr_en) busy[wr_sel] <= 1'b0;
            if (rsv_ack) busy[rsv_sel] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [SEL_W-1:0] sel;
        logic             hit;
        assign sel = rd_sel[p*SEL_W +: SEL_W];
        assign hit = wr_live && (wr_sel == sel);
        assign rd_data[p*DATA_W +: DATA_W] = (!run || sel == '0) ? '0 :
                                             hit ? wr_data : regs[sel];
        assign rd_busy[p] = run && (sel != '0) && busy[sel] && !hit;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard, compared every cycle
// against an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int NPORTS = 3;
    localparam int SEL_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     ready;
    logic [NPORTS*SEL_W-1:0]  rd_sel = '0;
    logic [NPORTS*DATA_W-1:0] rd_data;
    logic [NPORTS-1:0]        rd_busy;
    logic                     wr_en = 1'b0;
    logic [SEL_W-1:0]         wr_sel = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic                     rsv_en = 1'b0;
    logic [SEL_W-1:0]         rsv_sel = '0;
    logic                     rsv_ack;

    // clock / reset
    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W(DATA_W), .NUM_REGS(NREGS), .NUM_RD_PORTS(NPORTS)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_ack(rsv_ack)
    );

    // reference model
    logic [DATA_W-1:0] m_regs [NREGS];
    logic              m_busy [NREGS];
    int                m_clr_cycles = 0;
    bit                m_valid = 0;

    int n_cmp = 0;
    int n_err = 0;

    // last observed outputs, for directed checks
    logic                     obs_ready;
    logic                     obs_ack;
    logic [NPORTS*DATA_W-1:0] obs_data;
    logic [NPORTS-1:0]        obs_busy;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive on negedge, compare outputs, then advance model.
    task automatic step(input logic r, input logic we, input logic [SEL_W-1:0] ws,
                        input logic [DATA_W-1:0] wd, input logic re,
                        input logic [SEL_W-1:0] rs, input logic [NPORTS*SEL_W-1:0] rds);
        bit                run_e;
        bit                ack_e;
        logic [SEL_W-1:0]  s;
        bit                hit;
        @(negedge clk);
        rst = r; wr_en = we; wr_sel = ws; wr_data = wd;
        rsv_en = re; rsv_sel = rs; rd_sel = rds;
        #1;
        obs_ready = ready; obs_ack = rsv_ack; obs_data = rd_data; obs_busy = rd_busy;
        run_e = m_valid && (m_clr_cycles >= NREGS);
        ack_e = run_e && re && (rs != 0) && (!m_busy[rs] || (we && ws == rs));
        if (m_valid) begin
            check("ready", 32'(ready), 32'(run_e));
            check("rsv_ack", 32'(rsv_ack), 32'(ack_e));
            for (int p = 0; p < NPORTS; p++) begin
                s = rds[p*SEL_W +: SEL_W];
                hit = we && (ws == s);
                check($sformatf("rd_data[%0d] sel%0d", p, s), rd_data[p*DATA_W +: DATA_W],
                      (!run_e || s == 0) ? '0 : (hit ? wd : m_regs[s]));
                check($sformatf("rd_busy[%0d] sel%0d", p, s), 32'(rd_busy[p]),
                      32'(run_e && s != 0 && m_busy[s] && !hit));
            end
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1;
            m_clr_cycles = 0;
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
        end else if (m_valid && m_clr_cycles < NREGS) begin
            m_regs[m_clr_cycles] = '0;
            m_clr_cycles++;
        end else if (m_valid) begin
            if (we && ws != 0) m_regs[ws] = wd;
            if (we) m_busy[ws] = 0;
            if (ack_e) m_busy[rs] = 1;
        end
    endtask

    function automatic logic [SEL_W-1:0] rsel();
        // bias towards a few registers so collisions are frequent
        return ($urandom_range(0, 3) == 0) ? SEL_W'($urandom_range(0, 15))
                                           : SEL_W'($urandom_range(0, 4));
    endfunction

    task automatic rand_step(input logic r);
        logic [NPORTS*SEL_W-1:0] rds;
        for (int p = 0; p < NPORTS; p++) rds[p*SEL_W +: SEL_W] = rsel();
        step(r, 1'($urandom_range(0, 1)), rsel(), $urandom(),
             1'($urandom_range(0, 1)), rsel(), rds);
    endtask

    // Counts cycles after reset release until ready, bounded.
    task automatic expect_ready_after(input string tag);
        int n;
        n = 0;
        rand_step(1'b0);
        while (!obs_ready && n < 40) begin
            n++;
            rand_step(1'b0);
        end
        check(tag, 32'(n), 32'(NREGS));
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end

        repeat (3) rand_step(1'b1);
        expect_ready_after("ready latency after reset");

        step(0, 1, 4'd5, 32'hDEADBEEF, 0, 4'd0, {4'd0, 4'd0, 4'd5});
        check("bypass r5", obs_data[31:0], 32'hDEADBEEF);
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, {4'd0, 4'd0, 4'd5});
        check("stored r5", obs_data[31:0], 32'hDEADBEEF);

        step(0, 0, 4'd0, 32'h0, 1, 4'd7, {4'd0, 4'd0, 4'd7});
        check("rsv r7 ack", 32'(obs_ack), 32'd1);
        step(0, 0, 4'd0, 32'h0, 1, 4'd7, {4'd0, 4'd0, 4'd7});
        check("rsv r7 again nack", 32'(obs_ack), 32'd0);
        check("r7 busy", 32'(obs_busy[0]), 32'd1);
        step(0, 1, 4'd7, 32'h77, 0, 4'd0, {4'd0, 4'd0, 4'd7});
        check("r7 busy cleared by wb", 32'(obs_busy[0]), 32'd0);

        step(0, 0, 4'd0, 32'h0, 1, 4'd3, {4'd0, 4'd0, 4'd3});
        step(0, 1, 4'd3, 32'h33, 1, 4'd3, {4'd0, 4'd0, 4'd3});
        check("r3 wb+rsv ack", 32'(obs_ack), 32'd1);
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, {4'd0, 4'd0, 4'd3});
        check("r3 stays busy", 32'(obs_busy[0]), 32'd1);
        check("r3 updated", obs_data[31:0], 32'h33);

        step(0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, {4'd0, 4'd0, 4'd0});
        check("r0 reads zero", obs_data[31:0], 32'h0);
        check("r0 rsv nack", 32'(obs_ack), 32'd0);
        check("r0 not busy", 32'(obs_busy[0]), 32'd0);

        repeat (400) rand_step(1'b0);

        // reset in the middle of the clear sweep
        step(1, 0, 4'd0, 32'h0, 1, 4'd0, '0);
        repeat (9) rand_step(1'b0);
        rand_step(1'b1);
        expect_ready_after("ready latency after mid-clear reset");
        repeat (300) rand_step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
